// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands, op select and Start in;
// registered result, ZCNO flags, Busy and Done out.
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       FunSel;
   logic             Start;
   logic [WIDTH-1:0] OutALU;
   logic [3:0]       ZCNO;
   logic             Busy;
   logic             Done;

   modport master (
      output A, B, FunSel, Start,
      input  OutALU, ZCNO, Busy, Done
   );

   modport slave (
      input  A, B, FunSel, Start,
      output OutALU, ZCNO, Busy, Done
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete in IDLE, FunSel=F runs a shift-add
// multiplier over WIDTH cycles when ALU_SEQ_MUL_EN is defined (else F passes A).
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic      CLK,
   input  logic      RST,
   alu_seq_if.slave  bus
);

`ifdef ALU_SEQ_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'b00
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] outAlu_q, outAlu_d;
   logic [3:0]       zcno_q, zcno_d;
   logic             done_q, done_d;
   logic             busy;

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prodNext;
   logic               lastIter;
   logic               goMul;
`endif

   logic [WIDTH-1:0] aluRes;
   logic [WIDTH:0]   sumExt;
   logic             aluC;
   logic             aluO;
   logic             aluKeepFlags;
   logic [3:0]       aluZcno;
   logic             cin;

   assign cin = zcno_q[2];

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         outAlu_q <= '0;
         zcno_q   <= 4'b0000;
         done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         outAlu_q <= outAlu_d;
         zcno_q   <= zcno_d;
         done_q   <= done_d;
`ifdef ALU_SEQ_MUL_EN
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   // Single-cycle operation result and flags; C and O default to held values
   always_comb begin
      aluRes       = bus.A;
      sumExt       = '0;
      aluC         = cin;
      aluO         = zcno_q[0];
      aluKeepFlags = 1'b0;
      case (bus.FunSel)
         4'h0: aluRes = bus.A;
         4'h1: aluRes = bus.B;
         4'h2: aluRes = ~bus.A;
         4'h3: aluRes = ~bus.B;
         4'h4: begin
            sumExt = {1'b0, bus.A} + {1'b0, bus.B};
            aluRes = sumExt[WIDTH-1:0];
            aluC   = sumExt[WIDTH];
            aluO   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (aluRes[WIDTH-1] != bus.A[WIDTH-1]);
         end
         4'h5: begin
            sumExt = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, cin};
            aluRes = sumExt[WIDTH-1:0];
            aluC   = sumExt[WIDTH];
            aluO   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (aluRes[WIDTH-1] != bus.A[WIDTH-1]);
         end
         4'h6: begin
            sumExt = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
            aluRes = sumExt[WIDTH-1:0];
            aluC   = sumExt[WIDTH];
            aluO   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (aluRes[WIDTH-1] != bus.A[WIDTH-1]);
         end
         4'h7: aluRes = bus.A & bus.B;
         4'h8: aluRes = bus.A | bus.B;
         4'h9: aluRes = bus.A ^ bus.B;
         4'hA: begin
            aluRes = {bus.A[WIDTH-2:0], 1'b0};
            aluC   = bus.A[WIDTH-1];
         end
         4'hB: begin
            aluRes = {1'b0, bus.A[WIDTH-1:1]};
            aluC   = bus.A[0];
         end
         4'hC: begin
            aluRes = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
            aluC   = bus.A[0];
         end
         4'hD: begin
            aluRes = {bus.A[WIDTH-2:0], cin};
            aluC   = bus.A[WIDTH-1];
         end
         4'hE: begin
            aluRes = {cin, bus.A[WIDTH-1:1]};
            aluC   = bus.A[0];
         end
`ifndef ALU_SEQ_MUL_EN
         4'hF: aluKeepFlags = 1'b1;
`endif
         default: aluRes = bus.A;
      endcase
      aluZcno = aluKeepFlags ? zcno_q
                             : {(aluRes == '0), aluC, aluRes[WIDTH-1], aluO};
   end

`ifdef ALU_SEQ_MUL_EN
   assign goMul    = bus.Start && (bus.FunSel == 4'hF);
   assign lastIter = (cnt_q == CW'(WIDTH - 1));
   assign prodNext = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

   // Next-state logic; any unused encoding falls back to IDLE
   always_comb begin
      state_d = IDLE;
      case (state_q)
`ifdef ALU_SEQ_MUL_EN
         IDLE:    state_d = goMul ? MUL : IDLE;
         MUL:     state_d = lastIter ? IDLE : MUL;
`else
         IDLE:    state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      outAlu_d = outAlu_q;
      zcno_d   = zcno_q;
      done_d   = 1'b0;
      busy     = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef ALU_SEQ_MUL_EN
            if (goMul) begin
               mcand_d  = {{WIDTH{1'b0}}, bus.A};
               mplier_d = bus.B;
               prod_d   = '0;
               cnt_d    = '0;
            end else if (bus.Start) begin
`else
            if (bus.Start) begin
`endif
               outAlu_d = aluRes;
               zcno_d   = aluZcno;
               done_d   = 1'b1;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         MUL: begin
            busy     = 1'b1;
            prod_d   = prodNext;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CW'(1);
            if (lastIter) begin
               // O is not touched by the multiply; C flags a truncated product
               outAlu_d = prodNext[WIDTH-1:0];
               zcno_d   = {(prodNext[WIDTH-1:0] == '0), |prodNext[2*WIDTH-1:WIDTH],
                           prodNext[WIDTH-1], zcno_q[0]};
               done_d   = 1'b1;
               cnt_d    = '0;
            end
         end
`endif
         default: ;
      endcase
   end

   assign bus.OutALU = outAlu_q;
   assign bus.ZCNO   = zcno_q;
   assign bus.Done   = done_q;
   assign bus.Busy   = busy;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8); MUL checks compile in only with ALU_SEQ_MUL_EN.
module tb_alu_seq;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      logic [7:0] res;
      logic [3:0] flags;
      string      tag;
   } exp_t;

   exp_t sbQ[$];

   logic [7:0] sweepRes [13] = '{8'h05, 8'h02, 8'hFA, 8'hFD, 8'h07, 8'h07, 8'h03,
                                 8'h00, 8'h07, 8'h07, 8'h0A, 8'h02, 8'h02};
   logic [3:0] sweepFlg [13] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                 4'b0100, 4'b1100, 4'b0100, 4'b0100, 4'b0000, 4'b0100,
                                 4'b0100};

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(WIDTH)) bus ();

   alu_seq #(.WIDTH(WIDTH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pushExp(input string tag, input logic [7:0] er, input logic [3:0] ef);
      exp_t e;
      e.res   = er;
      e.flags = ef;
      e.tag   = tag;
      sbQ.push_back(e);
   endtask

   task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] fs, input logic [7:0] er, input logic [3:0] ef);
      @(negedge clk);
      bus.A      = a;
      bus.B      = b;
      bus.FunSel = fs;
      bus.Start  = 1'b1;
      pushExp(tag, er, ef);
      @(negedge clk);
      bus.Start = 1'b0;
      checkOutput({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sbQ.size() != 0) begin
         checkOutput("drain_timeout", sbQ.size(), 0);
         sbQ.delete();
      end
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst       = 1'b1;
      bus.Start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every Done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.Done) begin
         if (sbQ.size() == 0) begin
            checkOutput("spurious_done", {31'd0, bus.Done}, 32'd0);
         end else begin
            e = sbQ.pop_front();
            checkOutput({e.tag, "_res"}, {24'd0, bus.OutALU}, {24'd0, e.res});
            checkOutput({e.tag, "_zcno"}, {28'd0, bus.ZCNO}, {28'd0, e.flags});
         end
      end
   end

   initial begin
      int busyCnt;
      rst        = 1'b1;
      bus.A      = '0;
      bus.B      = '0;
      bus.FunSel = 4'h0;
      bus.Start  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_out",  {24'd0, bus.OutALU}, 32'd0);
      checkOutput("reset_zcno", {28'd0, bus.ZCNO},   32'd0);
      checkOutput("reset_busy", {31'd0, bus.Busy},   32'd0);
      checkOutput("reset_done", {31'd0, bus.Done},   32'd0);

      applyStimulus("add_basic",  8'h05, 8'h02, 4'h4, 8'h07, 4'b0000);
      applyStimulus("add_ovf",    8'h7F, 8'h01, 4'h4, 8'h80, 4'b0011);
      applyStimulus("sub_zero",   8'h05, 8'h05, 4'h6, 8'h00, 4'b1100);
      applyStimulus("and_hold_c", 8'h0F, 8'hF0, 4'h7, 8'h00, 4'b1100);
`ifndef ALU_SEQ_MUL_EN
      applyStimulus("f_passthru", 8'h3C, 8'h11, 4'hF, 8'h3C, 4'b1100);
`endif
      waitDrain(10);

      // Start held high for two cycles issues two requests
      @(negedge clk);
      bus.A = 8'h01; bus.B = 8'h01; bus.FunSel = 4'h4; bus.Start = 1'b1;
      pushExp("b2b_first", 8'h02, 4'b0000);
      @(negedge clk);
      bus.A = 8'hFF; bus.B = 8'h01;
      pushExp("b2b_second", 8'h00, 4'b1100);
      @(negedge clk);
      bus.Start = 1'b0;
      waitDrain(10);

      resetDut();
      for (int i = 0; i < 13; i++)
         applyStimulus($sformatf("sweep_%0h", i), 8'h05, 8'h02, 4'(i), sweepRes[i], sweepFlg[i]);
      applyStimulus("rol_c1", 8'h05, 8'h02, 4'hD, 8'h0B, 4'b0000);
      waitDrain(10);
      resetDut();
      applyStimulus("rol_c0",     8'h05, 8'h02, 4'hD, 8'h0A, 4'b0000);
      applyStimulus("ror_c0",     8'h05, 8'h02, 4'hE, 8'h02, 4'b0100);
      applyStimulus("adc_c1",     8'h05, 8'h02, 4'h5, 8'h08, 4'b0000);
      applyStimulus("asr_neg",    8'h84, 8'h00, 4'hC, 8'hC2, 4'b0010);
      applyStimulus("lsr_c",      8'h81, 8'h00, 4'hB, 8'h40, 4'b0100);
      applyStimulus("sub_borrow", 8'h02, 8'h05, 4'h6, 8'hFD, 4'b0010);
      applyStimulus("sub_ovf",    8'h80, 8'h01, 4'h6, 8'h7F, 4'b0101);
      waitDrain(10);

      // Reset wins over a simultaneous Start
      @(negedge clk);
      rst = 1'b1;
      bus.A = 8'h05; bus.B = 8'h02; bus.FunSel = 4'h4; bus.Start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.Start = 1'b0;
      checkOutput("rstprio_out",  {24'd0, bus.OutALU}, 32'd0);
      checkOutput("rstprio_zcno", {28'd0, bus.ZCNO},   32'd0);
      checkOutput("rstprio_done", {31'd0, bus.Done},   32'd0);
      @(negedge clk);
      checkOutput("rstprio_done_next", {31'd0, bus.Done}, 32'd0);

`ifdef ALU_SEQ_MUL_EN
      pushExp("mul", 8'h84, 4'b0010);
      @(negedge clk);
      bus.A = 8'h0C; bus.B = 8'h0B; bus.FunSel = 4'hF; bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      busyCnt = 0;
      for (int i = 0; i < 20 && bus.Busy; i++) begin
         busyCnt++;
         if (i == 2) begin
            bus.A = 8'hFF; bus.B = 8'hFF; bus.FunSel = 4'h4; bus.Start = 1'b1;
         end
         if (i == 3) bus.Start = 1'b0;
         @(negedge clk);
      end
      bus.Start = 1'b0;
      checkOutput("mul_busy_cycles", busyCnt, 8);
      waitDrain(5);

      @(negedge clk);
      bus.A = 8'h0C; bus.B = 8'h0B; bus.FunSel = 4'hF; bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mul_abort_out",  {24'd0, bus.OutALU}, 32'd0);
      checkOutput("mul_abort_zcno", {28'd0, bus.ZCNO},   32'd0);
      checkOutput("mul_abort_busy", {31'd0, bus.Busy},   32'd0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("mul_abort_nodone", {31'd0, bus.Done}, 32'd0);
         @(negedge clk);
      end
`endif

      applyStimulus("post_reset_add", 8'h05, 8'h02, 4'h4, 8'h07, 4'b0000);
      waitDrain(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 Ports (clock and reset first):
- CLK  in  1  single clock, all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- FunSel  in  4  operation select.
- Start  in  1  request; sampled only in IDLE.
- OutALU  out  WIDTH  registered result.
- ZCNO  out  4  registered flags: [3]=Z, [2]=C, [1]=N, [0]=O.
- Busy  out  1  high while a multi-cycle op runs.
- Done  out  1  one-cycle pulse; result and flags valid.

Function
REQ-003 FunSel decode: 0 A; 1 B; 2 NOT A; 3 NOT B; 4 A+B; 5 A+B+C; 6 A-B; 7 AND; 8 OR; 9 XOR; A LSL A; B LSR A; C ASR A; D rotate-left A through C; E rotate-right A through C; F MUL A*B (low WIDTH bits).
REQ-004 States IDLE and MUL only; unused state encodings return to IDLE on the next edge.
REQ-005 IDLE, Start=1, FunSel!=F: result and flags registered at that same edge; Done=1 the following cycle; Busy stays 0.
REQ-006 IDLE, Start=1, FunSel=F: A, B and FunSel latched at edge k; state MUL; Busy=1 after edge k.
REQ-007 MUL: one shift-add iteration per cycle; result and flags written at edge k+WIDTH; return to IDLE; Busy=0 and Done=1 the following cycle.
REQ-008 Start while Busy=1 is ignored; live A/B/FunSel changes during MUL have no effect.
REQ-009 Done is high for exactly one cycle per accepted request; Start held high in IDLE issues back-to-back requests, one per cycle.
REQ-010 Z = (result==0); N = result[WIDTH-1]; both updated by every op.
REQ-011 C: add ops = carry-out of bit WIDTH-1; subtract = carry-out of A + ~B + 1 (1 = no borrow); shifts/rotates = bit shifted out; MUL = OR of upper WIDTH product bits; ops 0-3 and 7-9 hold C.
REQ-012 O: updated by ops 4, 5, 6 only (signed two's-complement overflow); all other ops hold O.
REQ-013 Op 5 uses the ZCNO[2] value registered before the request; rotates insert that stored C.
REQ-014 OutALU and ZCNO hold their values between requests.

Reset
REQ-015 RST=1 at a rising edge: state IDLE, OutALU=0, ZCNO=4'b0000, Busy=0, Done=0, iteration counter=0.
REQ-016 RST during MUL aborts the operation; no Done pulse and no result or flag write occur.
REQ-017 RST takes priority over Start at the same edge.

Configuration
REQ-018 Macro ALU_SEQ_MUL_EN defined: FunSel F behaves per REQ-006/007 and the MUL state and multiplier datapath are present.
REQ-019 ALU_SEQ_MUL_EN undefined: no MUL state or datapath; FunSel F is single-cycle, OutALU=A, ZCNO unchanged, Done pulses, Busy stays 0.

Verification (WIDTH=8)
REQ-020 A=05, B=02, FunSel=4, Start pulse -> OutALU=07, ZCNO=0000, Done 1 cycle, Busy 0.
REQ-021 A=7F, B=01, FunSel=4 -> OutALU=80, ZCNO=0011 (N, O set).
REQ-022 A=05, B=05, FunSel=6 -> OutALU=00, ZCNO=1100; then FunSel=7, A=0F, B=F0 -> OutALU=00, ZCNO=1100 (C held).
REQ-023 ALU_SEQ_MUL_EN defined, A=0C, B=0B, FunSel=F -> Busy high 8 cycles; OutALU=84, ZCNO=0010; Done the cycle after Busy falls; second Start mid-op ignored.
REQ-024 RST asserted 3 cycles into MUL -> next cycle OutALU=00, ZCNO=0000, Busy=0, no Done pulse.
REQ-025 Sweep FunSel 0..E with A=05, B=02, C=0 -> results 05, 02, FA, FD, 07, 07, 03, 00, 07, 07, 0A, 02, 02, 0A, 02.
